router_pkt_ctrl: RTL and testbench
==================================

// Module: router_pkt_ctrl
// PURPOSE
// Ingress sequencer of the 1x3 router. Accepts the byte stream from the source
// (header {len[7:2],addr[1:0]}, len payload bytes, parity byte), steers each byte
// into one of three router_fifo instances with write_en/lfd_state, stalls the
// source with busy on FIFO full/not-empty, checks parity and runs per-output
// read-timeout timers that issue soft_reset to abandoned FIFOs.
// PARAMETERS
// TIMEOUT  30  consecutive unread cycles with vld_out[i]=1 before soft_reset[i]
// TMR_W    5   timer width; must satisfy 2**TMR_W > TIMEOUT
// PORTS
// clock       in   1  system clock, all state on rising edge
// resetn      in   1  asynchronous active-low reset
// pkt_valid   in   1  data_in holds a packet byte this cycle
// data_in     in   8  packet byte from source
// fifo_full   in   3  full flags of FIFO 0..2
// fifo_empty  in   3  empty flags of FIFO 0..2
// read_en     in   3  destination read strobes, FIFO 0..2
// busy        out  1  source must hold data_in; byte not accepted while 1
// write_en    out  3  one-hot FIFO write enable
// lfd_state   out  1  current write is the header byte
// data_out    out  8  byte to FIFO data_in (shared by all three)
// vld_out     out  3  ~fifo_empty, to destinations
// soft_reset  out  3  1-cycle FIFO flush pulse
// err         out  1  1-cycle pulse: parity mismatch
// BEHAVIOUR
// - Reset: state IDLE; hold/pend/hdr/addr/cnt/parity regs 0; all outputs 0
//   except vld_out = ~fifo_empty (combinational). Takes effect mid-packet.
// - accept = pkt_valid & ~busy. Accepted byte -> hold_q, pend_q=1; it is written
//   the following cycle (1-cycle latency): write_en[addr_q]=pend_q & ~fifo_full
//   [addr_q] & state!=WAIT_EMPTY; data_out=hold_q; lfd_state=write & hdr_q.
//   Written with no new accept -> pend_q=0.
// - busy (comb) = state==WAIT_EMPTY | state==PARITY_CHK | (pend_q & fifo_full[addr_q]).
//   Full stall: byte held in hold_q, retried every cycle, never lost/duplicated.
// - pkt_valid gaps inside a packet are legal; the controller counts bytes itself.
// - FSM: IDLE: on accept latch addr_q=data_in[1:0], cnt_q=data_in[7:2],
//   par_q=data_in, hdr_q=1. addr==3 -> DROP (no pend). Else fifo_empty[addr]
//   ? LOAD : WAIT_EMPTY.
//   WAIT_EMPTY: no writes; fifo_empty[addr_q] -> LOAD.
//   LOAD: accept with cnt_q!=0 -> par_q^=byte, cnt_q--; accept with cnt_q==0
//   -> byte is parity, -> PARITY_CHK. hdr_q clears on the header write.
//   PARITY_CHK: wait for pending parity write; on it err<=(hold_q!=par_q) next
//   cycle, -> IDLE. len=0 legal: header then parity.
//   DROP: consume cnt_q+1 further bytes, no writes, -> IDLE.
// - Timer i: clears on read_en[i] or ~vld_out[i] or soft_reset[i]; else +1.
//   Reaching TIMEOUT-1 -> soft_reset[i]=1 next cycle (exactly 1 cycle).
// - soft_reset[addr_q] while state in LOAD/WAIT_EMPTY/PARITY_CHK: pend_q=0,
//   -> DROP with remaining cnt_q (+0 if in PARITY_CHK, -> IDLE instead).
// - Simultaneous write and fifo_full rising: full sampled same cycle wins.
// STRUCTURE
// - router_pkg: state enum {IDLE,WAIT_EMPTY,LOAD,PARITY_CHK,DROP}, ADDR_INVALID
//   =2'b11, HDR_LEN_MSB/LSB=7/2, HDR_ADDR_MSB/LSB=1/0, NUM_OUT=3.
// - Sub-module router_rd_timer (#TIMEOUT,TMR_W), one per output; vld_out,
//   read_en in, soft_reset out. FSM, hold register, parity in the top.
// TESTING
// - Reset mid-packet (resetn low 1 cycle during LOAD) -> all outputs 0, IDLE,
//   next header 8'h39 accepted; no write_en before it.
// - Header 8'h39 (len 14, addr 1) + 14 bytes + correct parity, FIFO 1 empty
//   -> 16 writes on write_en=3'b010, lfd_state only on first, err=0.
// - Same packet, parity byte ^8'h01 -> err single-cycle pulse 1 cycle after
//   parity write; next packet unaffected.
// - fifo_full[1] forced high 5 cycles at payload byte 6 -> busy=1 5 cycles,
//   write_en[1]=0, byte 6 written once after release; order intact.
// - Header 8'h0B (addr 3, len 2) -> 3 further bytes consumed, write_en=0
//   throughout, back to IDLE; 8'h06 header to FIFO 2 then works.
// - vld_out[0]=1, read_en[0]=0 for 30 cycles -> soft_reset[0] pulses cycle 30
//   only; with read_en pulse at cycle 20 -> no soft_reset until cycle 50.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared types and header field positions for the router ingress controller.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LOAD,
        PARITY_CHK,
        DROP
    } state_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;
    localparam int NUM_OUT      = 3;
    localparam int LEN_W        = HDR_LEN_MSB - HDR_LEN_LSB + 1;

endpackage

// File: rtl/router_rd_timer.sv
// router_rd_timer: per-output read watchdog, pulses soft_reset when a FIFO is left unread.
// Ports:
//   clock      in   system clock
//   resetn     in   asynchronous active-low reset
//   vld_out    in   FIFO holds data for the destination
//   read_en    in   destination read strobe
//   soft_reset out  one-cycle flush pulse after TIMEOUT unread cycles
module router_rd_timer #(
    parameter int TIMEOUT = 30,
    parameter int TMR_W   = 5
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld_out,
    input  logic read_en,
    output logic soft_reset
);

    logic [TMR_W-1:0] cnt_q;
    logic             hit;

    // The pulse clears the counter on the following edge, so it lasts exactly one cycle.
    assign hit = vld_out & ~read_en & ~soft_reset & (cnt_q == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= '0;
            soft_reset <= 1'b0;
        end else begin
            cnt_q      <= (read_en | ~vld_out | soft_reset) ? '0 : cnt_q + 1'b1;
            soft_reset <= hit;
        end
    end

endmodule

// File: rtl/router_pkt_ctrl.sv
// router_pkt_ctrl: ingress sequencer steering packet bytes into three output FIFOs.
// Ports:
//   clock, resetn   clock and asynchronous active-low reset
//   pkt_valid       data_in holds a packet byte
//   data_in[7:0]    packet byte from the source
//   fifo_full[2:0]  full flags of FIFO 0..2
//   fifo_empty[2:0] empty flags of FIFO 0..2
//   read_en[2:0]    destination read strobes
//   busy            source must hold data_in
//   write_en[2:0]   one-hot FIFO write enable
//   lfd_state       current write is the header byte
//   data_out[7:0]   byte to the FIFOs
//   vld_out[2:0]    data available to each destination
//   soft_reset[2:0] one-cycle FIFO flush pulses
//   err             one-cycle parity mismatch pulse
module router_pkt_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30,
    parameter int TMR_W   = 5
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               pkt_valid,
    input  logic [7:0]         data_in,
    input  logic [NUM_OUT-1:0] fifo_full,
    input  logic [NUM_OUT-1:0] fifo_empty,
    input  logic [NUM_OUT-1:0] read_en,
    output logic               busy,
    output logic [NUM_OUT-1:0] write_en,
    output logic               lfd_state,
    output logic [7:0]         data_out,
    output logic [NUM_OUT-1:0] vld_out,
    output logic [NUM_OUT-1:0] soft_reset,
    output logic               err
);

    state_t           state_q, state_d;
    logic [7:0]       hold_q, par_q;
    logic             pend_q, hdr_q, err_q;
    logic [1:0]       addr_q, hdr_addr;
    logic [LEN_W-1:0] cnt_q;
    logic [3:0]       full_x, empty_x, sr_x;
    logic             accept, write, sel_full, sel_sr, cnt_zero, abort, in_idle;

    // Padding to four entries lets the 2-bit address index safely; address 3 never writes.
    assign full_x   = {1'b0, fifo_full};
    assign empty_x  = {1'b1, fifo_empty};
    assign sr_x     = {1'b0, soft_reset};
    assign hdr_addr = data_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
    assign sel_full = full_x[addr_q];
    assign sel_sr   = sr_x[addr_q];
    assign cnt_zero = (cnt_q == '0);
    assign accept   = pkt_valid & ~busy;
    assign in_idle  = (state_q == IDLE);
    assign abort    = sel_sr & (state_q == WAIT_EMPTY || state_q == LOAD || state_q == PARITY_CHK);
    assign vld_out  = ~fifo_empty;
    assign data_out = hold_q;
    assign err      = err_q;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_tmr
        router_rd_timer #(.TIMEOUT(TIMEOUT), .TMR_W(TMR_W)) u_tmr (
            .clock      (clock),
            .resetn     (resetn),
            .vld_out    (vld_out[i]),
            .read_en    (read_en[i]),
            .soft_reset (soft_reset[i])
        );
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (accept) state_d = (hdr_addr == ADDR_INVALID) ? DROP
                                            : empty_x[hdr_addr] ? LOAD : WAIT_EMPTY;
            WAIT_EMPTY: state_d = sel_sr ? DROP : empty_x[addr_q] ? LOAD : WAIT_EMPTY;
            // A byte accepted in the abort cycle still counts; if it was the parity byte nothing remains.
            LOAD:       state_d = sel_sr ? ((accept && cnt_zero) ? IDLE : DROP)
                                : (accept && cnt_zero) ? PARITY_CHK : LOAD;
            PARITY_CHK: state_d = (sel_sr || write) ? IDLE : PARITY_CHK;
            DROP:       state_d = (accept && cnt_zero) ? IDLE : DROP;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == WAIT_EMPTY) || (state_q == PARITY_CHK) || (pend_q && sel_full);
        write     = pend_q && !sel_full && (state_q != WAIT_EMPTY);
        write_en  = write ? (NUM_OUT'(1) << addr_q) : '0;
        lfd_state = write && hdr_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hold_q <= '0;
            par_q  <= '0;
            pend_q <= 1'b0;
            hdr_q  <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            err_q <= (state_q == PARITY_CHK) && write && (hold_q != par_q);
            if (accept) hold_q <= data_in;
            if (abort)                        pend_q <= 1'b0;
            else if (accept && in_idle)       pend_q <= (hdr_addr != ADDR_INVALID);
            else if (accept && state_q == LOAD) pend_q <= 1'b1;
            else if (write)                   pend_q <= 1'b0;
            if (accept && in_idle)            hdr_q <= 1'b1;
            else if (write || abort)          hdr_q <= 1'b0;
            if (accept && in_idle) begin
                addr_q <= hdr_addr;
                cnt_q  <= data_in[HDR_LEN_MSB:HDR_LEN_LSB];
                par_q  <= data_in;
            end else if (accept && !cnt_zero && (state_q == LOAD || state_q == DROP)) begin
                cnt_q  <= cnt_q - 1'b1;
                par_q  <= par_q ^ data_in;
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// tb_router_pkt_ctrl: scoreboard bench for the router ingress controller.
module tb_router_pkt_ctrl;

    typedef struct packed {
        logic [2:0] we;
        logic [7:0] d;
        logic       lfd;
        logic       last;
        logic       bad;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = '0;
    logic [2:0] fifo_full = '0;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] read_en = '0;
    logic       busy, lfd_state, err;
    logic [2:0] write_en, vld_out, soft_reset;
    logic [7:0] data_out;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic err_exp = 1'b0;

    router_pkt_ctrl dut (
        .clock      (clock),
        .resetn     (resetn),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .read_en    (read_en),
        .busy       (busy),
        .write_en   (write_en),
        .lfd_state  (lfd_state),
        .data_out   (data_out),
        .vld_out    (vld_out),
        .soft_reset (soft_reset),
        .err        (err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clock) begin
        exp_t e;
        #2;
        if (mon_en) begin
            n_cmp++;
            if (err !== err_exp) begin
                n_fail++;
                $display("FAIL err_pulse: got %b, want %b", err, err_exp);
            end
            err_exp = 1'b0;
            if (sb.size() == 0) begin
                n_cmp++;
                if (write_en !== 3'b000) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got we=%b d=%h, want we=000", write_en, data_out);
                end
            end else if (write_en !== 3'b000) begin
                e = sb.pop_front();
                n_cmp++;
                if ({write_en, data_out, lfd_state} !== {e.we, e.d, e.lfd}) begin
                    n_fail++;
                    $display("FAIL write: got we=%b d=%h lfd=%b, want we=%b d=%h lfd=%b",
                             write_en, data_out, lfd_state, e.we, e.d, e.lfd);
                end
                if (e.last) err_exp = e.bad;
            end
        end
    end

    task automatic push_exp(input logic [1:0] a, input logic [7:0] d, input logic lfd,
                            input logic last, input logic bad);
        exp_t e;
        e.we = 3'b001 << a;
        e.d = d;
        e.lfd = lfd;
        e.last = last;
        e.bad = bad;
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        pkt_valid = 1'b1;
        data_in = b;
        #1;
        while (busy && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: busy=%b after %0d cycles, want 0", busy, n);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic corrupt);
        logic [7:0] par, b;
        logic       keep;
        keep = (hdr[1:0] != 2'b11);
        par = hdr;
        if (keep) push_exp(hdr[1:0], hdr, 1'b1, 1'b0, 1'b0);
        send(hdr);
        for (int i = 0; i < int'(hdr[7:2]); i++) begin
            b = 8'($urandom);
            par ^= b;
            if (keep) push_exp(hdr[1:0], b, 1'b0, 1'b0, 1'b0);
            send(b);
        end
        par ^= {7'd0, corrupt};
        if (keep) push_exp(hdr[1:0], par, 1'b0, 1'b1, corrupt);
        send(par);
        pkt_valid = 1'b0;
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({busy, write_en, lfd_state, data_out, soft_reset, err} !== 17'd0) begin
            n_fail++;
            $display("FAIL por_outputs: got %h, want 0", {busy, write_en, lfd_state, data_out, soft_reset, err});
        end
        @(negedge clock);
        resetn = 1'b1;
        send(8'h39);
        for (int i = 0; i < 4; i++) send(8'(i + 8'hA0));
        resetn = 1'b0;
        pkt_valid = 1'b0;
        fifo_empty = 3'b011;
        #2;
        n_cmp++;
        if ({busy, write_en, lfd_state, data_out, soft_reset, err} !== 17'd0) begin
            n_fail++;
            $display("FAIL midpkt_reset_outputs: got %h, want 0", {busy, write_en, lfd_state, data_out, soft_reset, err});
        end
        n_cmp++;
        if (vld_out !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_vld_out: got %b, want 100", vld_out);
        end
        @(negedge clock);
        resetn = 1'b1;
        fifo_empty = 3'b111;
        sb.delete();
        mon_en = 1'b1;
        repeat (3) @(negedge clock);
        send_pkt(8'h39, 1'b0);
        repeat (4) @(negedge clock);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_drain: %0d writes missing, want 0", sb.size());
        end
    endtask

    task automatic test_packet;
        @(negedge clock);
        send_pkt(8'h39, 1'b0);
        repeat (4) @(negedge clock);
        n_cmp++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL packet_drain: left=%0d busy=%b, want 0 and 0", sb.size(), busy);
        end
    endtask

    task automatic test_parity_err;
        @(negedge clock);
        send_pkt(8'h39, 1'b1);
        send_pkt(8'h39, 1'b0);
        repeat (4) @(negedge clock);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL parity_drain: %0d writes missing, want 0", sb.size());
        end
    endtask

    task automatic test_full_stall;
        logic [7:0] par, b;
        int nb;
        @(negedge clock);
        push_exp(2'd1, 8'h39, 1'b1, 1'b0, 1'b0);
        send(8'h39);
        par = 8'h39;
        for (int i = 0; i < 14; i++) begin
            b = 8'($urandom);
            par ^= b;
            push_exp(2'd1, b, 1'b0, 1'b0, 1'b0);
            send(b);
            if (i == 6) begin
                fifo_full = 3'b010;
                nb = 0;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    if (busy) nb++;
                    n_cmp++;
                    if (write_en[1] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_write: got write_en=%b while full, want 000", write_en);
                    end
                    @(negedge clock);
                end
                fifo_full = 3'b000;
                n_cmp++;
                if (nb != 5) begin
                    n_fail++;
                    $display("FAIL stall_busy: got %0d busy cycles, want 5", nb);
                end
            end
        end
        push_exp(2'd1, par, 1'b0, 1'b1, 1'b0);
        send(par);
        pkt_valid = 1'b0;
        repeat (4) @(negedge clock);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL stall_drain: %0d writes missing, want 0", sb.size());
        end
    endtask

    task automatic test_wait_empty;
        logic [7:0] b;
        @(negedge clock);
        fifo_empty = 3'b110;
        b = 8'h5C;
        push_exp(2'd0, 8'h04, 1'b1, 1'b0, 1'b0);
        push_exp(2'd0, b, 1'b0, 1'b0, 1'b0);
        push_exp(2'd0, 8'h04 ^ b, 1'b0, 1'b1, 1'b0);
        send(8'h04);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (busy !== 1'b1 || write_en !== 3'b000) begin
                n_fail++;
                $display("FAIL wait_empty: got busy=%b we=%b, want 1 and 000", busy, write_en);
            end
            @(negedge clock);
        end
        fifo_empty = 3'b111;
        send(b);
        send(8'h04 ^ b);
        pkt_valid = 1'b0;
        repeat (4) @(negedge clock);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL wait_empty_drain: %0d writes missing, want 0", sb.size());
        end
    endtask

    task automatic test_drop;
        @(negedge clock);
        send(8'h0B);
        for (int i = 0; i < 3; i++) begin
            send(8'(8'h10 + i));
        end
        pkt_valid = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || write_en !== 3'b000) begin
            n_fail++;
            $display("FAIL drop_idle: got busy=%b we=%b, want 0 and 000", busy, write_en);
        end
        @(negedge clock);
        send_pkt(8'h06, 1'b0);
        repeat (4) @(negedge clock);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drop_next_drain: %0d writes missing, want 0", sb.size());
        end
    endtask

    task automatic test_timeout;
        logic [2:0] want;
        @(negedge clock);
        fifo_empty = 3'b110;
        for (int c = 1; c <= 35; c++) begin
            @(posedge clock);
            #1;
            want = (c == 30) ? 3'b001 : 3'b000;
            n_cmp++;
            if (soft_reset !== want) begin
                n_fail++;
                $display("FAIL timeout_a c=%0d: got soft_reset=%b, want %b", c, soft_reset, want);
            end
        end
        fifo_empty = 3'b111;
        repeat (2) @(negedge clock);
        fifo_empty = 3'b110;
        for (int c = 1; c <= 55; c++) begin
            read_en = (c == 20) ? 3'b001 : 3'b000;
            @(posedge clock);
            #1;
            want = (c == 50) ? 3'b001 : 3'b000;
            n_cmp++;
            if (soft_reset !== want) begin
                n_fail++;
                $display("FAIL timeout_b c=%0d: got soft_reset=%b, want %b", c, soft_reset, want);
            end
        end
        read_en = 3'b000;
        fifo_empty = 3'b111;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        test_reset;
        test_packet;
        test_parity_err;
        test_full_stall;
        test_wait_empty;
        test_drop;
        test_timeout;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
